// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer.
// State encoding, 50 MHz note half-periods and the note-entry bundle.
package melody_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [15:0] D5   = 16'd42589;
    localparam logic [15:0] E5   = 16'd37936;
    localparam logic [15:0] F5S  = 16'd33784;
    localparam logic [15:0] G5   = 16'd31888;
    localparam logic [15:0] A5   = 16'd28409;
    localparam logic [15:0] B5   = 16'd25304;
    localparam logic [15:0] REST = 16'd0;

    typedef struct packed {
        logic [15:0] hp;
        logic [23:0] dur;
    } note_t;

endpackage

// File: rtl/tone_divider.sv
// Half-period counter and square-wave toggle.
// Ports: clk, rst_n, clr (zero counter+output), en, half_period, tone.
module tone_divider #(
    parameter int HP_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            tone
);

    logic [HP_W-1:0] cnt_q;
    logic            tone_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else if (clr || half_period == '0) begin
            // a zero half-period is a rest: hold the output low
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else if (en) begin
            if (cnt_q == half_period - HP_W'(1)) begin
                cnt_q  <= '0;
                tone_q <= ~tone_q;
            end else begin
                cnt_q <= cnt_q + HP_W'(1);
            end
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/melody_sequencer.sv
// Programmable square-wave melody player: runtime note table, tone/gap FSM.
// Ports: table write (wr_*), length/loop_en/start/stop control,
// speaker/busy/note_idx/done status. Option MELODY_SEQ_TEMPO_EN adds tempo.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int HP_W       = 16,
    parameter int DUR_W      = 24,
    parameter int GAP_CYCLES = 400000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [HP_W-1:0]  wr_half_period,
    input  logic [DUR_W-1:0] wr_duration,
    input  logic [IDX_W:0]   length,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
`ifdef MELODY_SEQ_TEMPO_EN
    input  logic [1:0]       tempo,
`endif
    output logic             speaker,
    output logic             busy,
    output logic [IDX_W-1:0] note_idx,
    output logic             done
);

`ifdef MELODY_SEQ_TEMPO_EN
    localparam int DC_W = DUR_W + 3;
`else
    localparam int DC_W = DUR_W;
`endif
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [HP_W-1:0]  hp_mem  [DEPTH];
    logic [DUR_W-1:0] dur_mem [DEPTH];

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W:0]   len_q;
    logic [HP_W-1:0]  cur_hp_q;
    logic [DUR_W-1:0] cur_dur_q;
    logic [DC_W-1:0]  dur_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             busy_q;
    logic             done_q;
`ifdef MELODY_SEQ_TEMPO_EN
    logic [1:0]       tempo_q;
`endif

    logic [DUR_W-1:0] dur_base;
    logic [DC_W-1:0]  dur_last;
    logic [IDX_W:0]   idx_inc;
    logic             len_ok;
    logic             dur_end;
    logic             tone_run;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            hp_mem[wr_addr]  <= wr_half_period;
            dur_mem[wr_addr] <= wr_duration;
        end
    end

    // zero duration plays for a single cycle
    assign dur_base = (cur_dur_q == '0) ? DUR_W'(1) : cur_dur_q;
`ifdef MELODY_SEQ_TEMPO_EN
    assign dur_last = (DC_W'(dur_base) << tempo_q) - DC_W'(1);
`else
    assign dur_last = dur_base - DUR_W'(1);
`endif

    assign idx_inc  = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign len_ok   = (length != '0) && (length <= (IDX_W+1)'(DEPTH));
    assign dur_end  = (dur_cnt_q == dur_last);
    assign tone_run = (state_q == TONE) && !dur_end && !stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            cur_hp_q  <= '0;
            cur_dur_q <= '0;
            dur_cnt_q <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MELODY_SEQ_TEMPO_EN
            tempo_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q   <= IDLE;
                idx_q     <= '0;
                dur_cnt_q <= '0;
                gap_cnt_q <= '0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start && len_ok) begin
                            state_q   <= TONE;
                            busy_q    <= 1'b1;
                            idx_q     <= '0;
                            len_q     <= length;
                            cur_hp_q  <= hp_mem[0];
                            cur_dur_q <= dur_mem[0];
                            dur_cnt_q <= '0;
`ifdef MELODY_SEQ_TEMPO_EN
                            tempo_q   <= tempo;
`endif
                        end
                    end
                    TONE: begin
                        if (dur_end) begin
                            state_q   <= GAP;
                            gap_cnt_q <= '0;
                        end else begin
                            dur_cnt_q <= dur_cnt_q + DC_W'(1);
                        end
                    end
                    GAP: begin
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_q <= '0;
                            dur_cnt_q <= '0;
                            if (idx_inc < len_q) begin
                                state_q   <= TONE;
                                idx_q     <= idx_inc[IDX_W-1:0];
                                cur_hp_q  <= hp_mem[idx_inc[IDX_W-1:0]];
                                cur_dur_q <= dur_mem[idx_inc[IDX_W-1:0]];
                            end else if (loop_en) begin
                                state_q   <= TONE;
                                idx_q     <= '0;
                                cur_hp_q  <= hp_mem[0];
                                cur_dur_q <= dur_mem[0];
`ifdef MELODY_SEQ_TEMPO_EN
                                tempo_q   <= tempo;
`endif
                            end else begin
                                state_q <= IDLE;
                                idx_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // divider is cleared on every TONE entry and whenever TONE is left
    tone_divider #(
        .HP_W(HP_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (!tone_run),
        .en         (tone_run),
        .half_period(cur_hp_q),
        .tone       (speaker)
    );

    assign busy     = busy_q;
    assign note_idx = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer (DEPTH=4, GAP=4).
// Covers one-shot, rest, loop, stop/start edge cases, reset and tempo.
module tb_melody_sequencer;

    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
    localparam int HP_W  = 16;
    localparam int DUR_W = 24;
    localparam int GAP   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_addr = '0;
    logic [HP_W-1:0]  wr_half_period = '0;
    logic [DUR_W-1:0] wr_duration = '0;
    logic [IDX_W:0]   length = '0;
    logic             loop_en = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
`ifdef MELODY_SEQ_TEMPO_EN
    logic [1:0]       tempo = '0;
`endif
    logic             speaker;
    logic             busy;
    logic [IDX_W-1:0] note_idx;
    logic             done;

    int checks = 0;
    int failures = 0;

    melody_sequencer #(
        .DEPTH(DEPTH),
        .HP_W(HP_W),
        .DUR_W(DUR_W),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_half_period(wr_half_period),
        .wr_duration(wr_duration),
        .length(length),
        .loop_en(loop_en),
        .start(start),
        .stop(stop),
`ifdef MELODY_SEQ_TEMPO_EN
        .tempo(tempo),
`endif
        .speaker(speaker),
        .busy(busy),
        .note_idx(note_idx),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int hp, input int dur);
        wr_en = 1'b1;
        wr_addr = IDX_W'(a);
        wr_half_period = HP_W'(hp);
        wr_duration = DUR_W'(dur);
        tick();
        wr_en = 1'b0;
    endtask

    // Checks a full note: square wave with first toggle after hp cycles.
    task automatic play(input int hp, input int dur, input int idx,
                        input bit poke);
        logic [IDX_W:0] saved;
        int exp_spk;
        for (int c = 1; c <= dur; c++) begin
            exp_spk = (hp == 0) ? 0 : (((c - 1) / hp) % 2);
            chk($sformatf("spk n%0d c%0d", idx, c), int'(speaker), exp_spk);
            chk($sformatf("busy n%0d c%0d", idx, c), int'(busy), 1);
            chk($sformatf("idx n%0d c%0d", idx, c), int'(note_idx), idx);
            chk($sformatf("done n%0d c%0d", idx, c), int'(done), 0);
            if (poke && c == 2) begin
                saved = length;
                start = 1'b1;
                length = 1;
                tick();
                start = 1'b0;
                length = saved;
            end else begin
                tick();
            end
        end
    endtask

    task automatic gap(input int idx);
        for (int g = 1; g <= GAP; g++) begin
            chk($sformatf("gap spk n%0d g%0d", idx, g), int'(speaker), 0);
            chk($sformatf("gap busy n%0d g%0d", idx, g), int'(busy), 1);
            chk($sformatf("gap idx n%0d g%0d", idx, g), int'(note_idx), idx);
            chk($sformatf("gap done n%0d g%0d", idx, g), int'(done), 0);
            tick();
        end
    endtask

    task automatic expect_done();
        chk("end busy", int'(busy), 0);
        chk("end done", int'(done), 1);
        chk("end spk", int'(speaker), 0);
        tick();
        chk("end done clr", int'(done), 0);
        chk("end busy2", int'(busy), 0);
    endtask

    task automatic go(input int len, input bit lp);
        length = (IDX_W+1)'(len);
        loop_en = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst spk", int'(speaker), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst idx", int'(note_idx), 0);
        chk("rst done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // one-shot two-note sequence: 12+4+8+4 busy cycles
        wr(0, 3, 12);
        wr(1, 2, 8);
        wr(2, 0, 10);
        go(2, 1'b0);
        play(3, 12, 0, 1'b0);
        gap(0);
        play(2, 8, 1, 1'b0);
        gap(1);
        expect_done();

        // looping with a rest entry; start while busy is ignored
        go(3, 1'b1);
        play(3, 12, 0, 1'b0);
        gap(0);
        play(2, 8, 1, 1'b1);
        gap(1);
        play(0, 10, 2, 1'b0);
        gap(2);
        play(3, 12, 0, 1'b0);
        gap(0);
        play(2, 8, 1, 1'b0);
        gap(1);
        loop_en = 1'b0;
        play(0, 10, 2, 1'b0);
        gap(2);
        expect_done();

        // stop during GAP
        go(2, 1'b0);
        play(3, 12, 0, 1'b0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop busy", int'(busy), 0);
        chk("stop idx", int'(note_idx), 0);
        chk("stop done", int'(done), 0);
        chk("stop spk", int'(speaker), 0);
        tick();
        chk("stop done2", int'(done), 0);
        chk("stop busy2", int'(busy), 0);

        // illegal lengths and start+stop collision
        go(0, 1'b0);
        chk("len0 busy", int'(busy), 0);
        tick();
        chk("len0 busy2", int'(busy), 0);
        go(5, 1'b0);
        chk("len5 busy", int'(busy), 0);
        stop = 1'b1;
        go(2, 1'b0);
        stop = 1'b0;
        chk("startstop busy", int'(busy), 0);
        tick();
        chk("startstop busy2", int'(busy), 0);

`ifdef MELODY_SEQ_TEMPO_EN
        // tempo=2 stretches a 5-cycle note to 20 cycles, gap unchanged
        wr(0, 2, 5);
        tempo = 2'd2;
        go(1, 1'b0);
        tempo = 2'd0;
        play(2, 20, 0, 1'b0);
        gap(0);
        expect_done();
`endif

        // reset mid-TONE forces speaker low immediately
        wr(0, 1, 20);
        go(1, 1'b0);
        chk("hp1 c1", int'(speaker), 0);
        tick();
        chk("hp1 c2", int'(speaker), 1);
        rst_n = 1'b0;
        #1;
        chk("async rst spk", int'(speaker), 0);
        chk("async rst busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post rst busy", int'(busy), 0);
        chk("post rst spk", int'(speaker), 0);
        chk("post rst idx", int'(note_idx), 0);
        tick();
        chk("post rst spk2", int'(speaker), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
